// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 encodings of the M-extension ops
//   - FSM state encoding
//   - special-case quotients for divide-by-zero and signed overflow
package md_pkg;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [31:0] MD_DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] MD_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/md_step.sv
// md_step: combinational single-iteration datapath shared by multiply and
// divide.
//   acc_in     : upper accumulator (multiply) / partial remainder (divide)
//   shreg_in   : multiplier, consumed LSB-first (multiply) /
//                dividend, consumed MSB-first (divide)
//   operand    : multiplicand magnitude / divisor magnitude
//   is_div     : selects the restoring-divide step
//   acc_next   : next accumulator / partial remainder
//   shreg_next : next shift register (divide: shifted left, bit 0 left clear)
//   q_bit      : quotient bit produced by this divide step (0 for multiply)
module md_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   acc_in,
    input  logic [XLEN-1:0] shreg_in,
    input  logic [XLEN-1:0] operand,
    input  logic            is_div,
    output logic [XLEN:0]   acc_next,
    output logic [XLEN-1:0] shreg_next,
    output logic            q_bit
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        // Multiply: conditionally add, then shift the whole 65-bit pair right
        // so the carry lands in the top bit of the product.
        sum     = acc_in + {1'b0, (shreg_in[0] ? operand : {XLEN{1'b0}})};
        // Divide: bring down the next dividend bit and trial-subtract.
        shifted = {acc_in[XLEN-1:0], shreg_in[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, operand};

        q_bit      = 1'b0;
        acc_next   = {1'b0, sum[XLEN:1]};
        shreg_next = {sum[0], shreg_in[XLEN-1:1]};

        if (is_div) begin
            // A clear borrow bit means the trial subtraction fits.
            q_bit      = ~diff[XLEN+1];
            acc_next   = q_bit ? diff[XLEN:0] : shifted;
            shreg_next = {shreg_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit in the execute stage.
//   clk, cpurst           : core clock, asynchronous active-low reset
//   de2ex_*_ffout         : registered decode-to-execute bundle
//   ex_hold               : downstream stall; extends DONE while high
//   mult_stall            : freezes fetch/decode/de_ex while an op is in flight
//   md_valid, md_result   : registered result for the writeback mux
// Works on operand magnitudes and applies the result sign when entering DONE.
module ex_muldiv
    import md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clk,
    input  logic            cpurst,
    input  logic            de2ex_MD_OP_ffout,
    input  logic            de2ex_inst_valid_ffout,
    input  logic [2:0]      de2ex_aluop_ffout,
    input  logic [XLEN-1:0] de2ex_rd_oprand1_ffout,
    input  logic [XLEN-1:0] de2ex_rd_oprand2_ffout,
    input  logic            ex_hold,
    output logic            mult_stall,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    md_state_t         state_reg;
    logic [2:0]        op_reg;
    logic [CW-1:0]     cnt_reg;
    logic [XLEN:0]     hi_reg;
    logic [XLEN-1:0]   lo_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic              neg_reg;
    logic [XLEN-1:0]   result_reg;
    logic              valid_reg;

    logic              req;
    logic              rs1_signed, rs2_signed;
    logic              sign1, sign2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              is_rem_in, div0, ovf;
    logic              neg_in;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     step_hi;
    logic [XLEN-1:0]   step_lo;
    logic              step_q;
    logic [XLEN-1:0]   lo_new;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   div_val, div_s;
    logic [XLEN-1:0]   final_res;

    // Request decode and operand preparation
    always_comb begin
        req        = de2ex_MD_OP_ffout & de2ex_inst_valid_ffout;
        rs1_signed = (de2ex_aluop_ffout == MD_MUL)    || (de2ex_aluop_ffout == MD_MULH) ||
                     (de2ex_aluop_ffout == MD_MULHSU) || (de2ex_aluop_ffout == MD_DIV)  ||
                     (de2ex_aluop_ffout == MD_REM);
        rs2_signed = (de2ex_aluop_ffout == MD_MUL) || (de2ex_aluop_ffout == MD_MULH) ||
                     (de2ex_aluop_ffout == MD_DIV) || (de2ex_aluop_ffout == MD_REM);
        sign1      = rs1_signed & de2ex_rd_oprand1_ffout[XLEN-1];
        sign2      = rs2_signed & de2ex_rd_oprand2_ffout[XLEN-1];
        mag1       = sign1 ? -de2ex_rd_oprand1_ffout : de2ex_rd_oprand1_ffout;
        mag2       = sign2 ? -de2ex_rd_oprand2_ffout : de2ex_rd_oprand2_ffout;
        is_rem_in  = de2ex_aluop_ffout[2] & de2ex_aluop_ffout[1];
        div0       = de2ex_aluop_ffout[2] & (de2ex_rd_oprand2_ffout == '0);
        ovf        = ((de2ex_aluop_ffout == MD_DIV) || (de2ex_aluop_ffout == MD_REM)) &&
                     (de2ex_rd_oprand1_ffout == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (de2ex_rd_oprand2_ffout == '1);
        // Remainder takes the dividend's sign; everything else sign1 ^ sign2.
        neg_in     = is_rem_in ? sign1 : (sign1 ^ sign2);
        if (div0)
            special_res = is_rem_in ? de2ex_rd_oprand1_ffout : MD_DIV0_Q;
        else
            special_res = is_rem_in ? '0 : MD_OVF_Q;
    end

    md_step #(.XLEN(XLEN)) u_step (
        .acc_in     (hi_reg),
        .shreg_in   (lo_reg),
        .operand    (opnd_reg),
        .is_div     (op_reg[2]),
        .acc_next   (step_hi),
        .shreg_next (step_lo),
        .q_bit      (step_q)
    );

    // Final-step result with sign applied; registered on DONE entry.
    always_comb begin
        lo_new  = step_lo | {{(XLEN-1){1'b0}}, step_q};
        prod    = {step_hi[XLEN-1:0], lo_new};
        // Negate the full 64-bit product so the high half is correct.
        prod_s  = neg_reg ? -prod : prod;
        div_val = op_reg[1] ? step_hi[XLEN-1:0] : lo_new;
        div_s   = neg_reg ? -div_val : div_val;
        if (op_reg[2])
            final_res = div_s;
        else if (op_reg == MD_MUL)
            final_res = prod_s[XLEN-1:0];
        else
            final_res = prod_s[2*XLEN-1:XLEN];
    end

    // Combinational so the request cycle itself already freezes the front end.
    assign mult_stall = ((state_reg == MD_IDLE) && req) || (state_reg == MD_CALC);
    assign md_valid   = valid_reg;
    assign md_result  = result_reg;

    always_ff @(posedge clk or negedge cpurst) begin
        if (!cpurst) begin
            state_reg  <= MD_IDLE;
            op_reg     <= '0;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opnd_reg   <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (req) begin
                        op_reg   <= de2ex_aluop_ffout;
                        neg_reg  <= neg_in;
                        cnt_reg  <= '0;
                        hi_reg   <= '0;
                        lo_reg   <= mag1;
                        opnd_reg <= mag2;
                        if (div0 || ovf) begin
                            result_reg <= special_res;
                            valid_reg  <= 1'b1;
                            state_reg  <= MD_DONE;
                        end else begin
                            state_reg  <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    hi_reg  <= step_hi;
                    lo_reg  <= lo_new;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_STEP) begin
                        result_reg <= final_res;
                        valid_reg  <= 1'b1;
                        state_reg  <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    // de_ex advances on the exit edge, so no re-trigger.
                    if (!ex_hold) begin
                        valid_reg <= 1'b0;
                        state_reg <= MD_IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed, table-driven check of ex_muldiv results, stall
// length, valid timing, ex_hold extension, back-to-back issue and reset
// during an operation.
module tb_ex_muldiv;

    logic        clk;
    logic        cpurst;
    logic        md_op;
    logic        inst_valid;
    logic [2:0]  aluop;
    logic [31:0] rs1, rs2;
    logic        ex_hold;
    logic        mult_stall;
    logic        md_valid;
    logic [31:0] md_result;

    int total_cnt = 0;
    int pass_cnt  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[18];

    ex_muldiv #(.XLEN(32), .STEPS(32)) dut (
        .clk                    (clk),
        .cpurst                 (cpurst),
        .de2ex_MD_OP_ffout      (md_op),
        .de2ex_inst_valid_ffout (inst_valid),
        .de2ex_aluop_ffout      (aluop),
        .de2ex_rd_oprand1_ffout (rs1),
        .de2ex_rd_oprand2_ffout (rs2),
        .ex_hold                (ex_hold),
        .mult_stall             (mult_stall),
        .md_valid               (md_valid),
        .md_result              (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Issues one M op right after a rising edge and follows it through DONE.
    // Leaves the bench just after the edge that leaves DONE, so the caller
    // may present the next instruction in the same cycle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input int hold);
        int cyc;
        int stalls;
        logic got;
        logic [31:0] first_res;
        md_op      = 1'b1;
        inst_valid = 1'b1;
        aluop      = op;
        rs1        = a;
        rs2        = b;
        ex_hold    = (hold > 0);
        cyc    = 0;
        stalls = 0;
        got    = 1'b0;
        while (cyc < 100) begin
            @(negedge clk);
            if (md_valid) begin
                got = 1'b1;
                break;
            end
            if (mult_stall) stalls++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("valid_seen", {31'd0, got}, 32'd1);
        check("valid_cycle", cyc, exp_lat);
        check("stall_cycles", stalls, exp_lat);
        check("result", md_result, exp_res);
        check("stall_in_done", {31'd0, mult_stall}, 32'd0);
        first_res = md_result;
        $display("op=%0d a=%h b=%h result=%h exp=%h valid_cycle=%0d stalls=%0d hold=%0d",
                 op, a, b, md_result, exp_res, cyc, stalls, hold);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            ex_hold = (h < hold - 1);
            @(negedge clk);
            check("hold_valid", {31'd0, md_valid}, 32'd1);
            check("hold_result", md_result, first_res);
            check("hold_stall", {31'd0, mult_stall}, 32'd0);
        end
        @(posedge clk);
        #1;
        ex_hold = 1'b0;
    endtask

    initial begin
        cpurst     = 1'b0;
        md_op      = 1'b0;
        inst_valid = 1'b0;
        aluop      = 3'd0;
        rs1        = '0;
        rs2        = '0;
        ex_hold    = 1'b0;

        //        op    rs1            rs2            expected       lat hold
        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 4};
        vecs[1]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33, 0};
        vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0};
        vecs[4]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33, 0};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF,  1, 0};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,          1, 0};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,  1, 0};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1, 0};
        vecs[12] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0};
        vecs[13] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 0};
        vecs[14] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0,         33, 0};
        vecs[15] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         33, 0};
        vecs[16] = '{3'd4, 32'h8000_0000, 32'd1,         32'h8000_0000, 33, 2};
        vecs[17] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 0};

        // Reset values
        #3;
        check("rst_stall", {31'd0, mult_stall}, 32'd0);
        check("rst_valid", {31'd0, md_valid}, 32'd0);
        check("rst_result", md_result, 32'd0);
        @(negedge clk);
        cpurst = 1'b1;
        @(posedge clk);
        #1;

        // Table, issued back to back (vector 1 follows the held vector 0).
        foreach (vecs[i])
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].hold);

        // Idle after request drops
        md_op      = 1'b0;
        inst_valid = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'd0, mult_stall}, 32'd0);
        check("idle_valid", {31'd0, md_valid}, 32'd0);

        // Valid instruction that is not an M op must not start anything
        inst_valid = 1'b1;
        aluop      = 3'd0;
        rs1        = 32'd3;
        rs2        = 32'd4;
        @(negedge clk);
        check("non_md_stall", {31'd0, mult_stall}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("non_md_valid", {31'd0, md_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Reset at CALC step 10
        md_op      = 1'b1;
        inst_valid = 1'b1;
        aluop      = 3'd0;
        rs1        = 32'h0000_1234;
        rs2        = 32'h0000_5678;
        repeat (11) @(posedge clk);
        #2;
        check("calc_stall", {31'd0, mult_stall}, 32'd1);
        cpurst     = 1'b0;
        md_op      = 1'b0;
        inst_valid = 1'b0;
        #1;
        check("midrst_stall", {31'd0, mult_stall}, 32'd0);
        check("midrst_valid", {31'd0, md_valid}, 32'd0);
        check("midrst_result", md_result, 32'd0);
        $display("reset at calc step 10: stall=%b valid=%b result=%h", mult_stall, md_valid, md_result);
        @(negedge clk);
        cpurst = 1'b1;
        @(posedge clk);
        #1;
        do_op(3'd0, 32'd3, 32'd4, 32'd12, 33, 0);
        md_op      = 1'b0;
        inst_valid = 1'b0;
        @(negedge clk);
        check("final_idle_valid", {31'd0, md_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
